// File: rtl/loop_counter_2d_if.sv
// Control/status bundle for the two-level loop counter.
// The master (controller or bench) drives the control inputs and limits.
// The slave (the counter) returns the counts, the one-cycle pulses and busy.
interface loop_counter_2d_if #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 6
);
    logic             start;
    logic             en;
    logic             clear;
    logic             mode;
    logic [IN_W-1:0]  inner_max;
    logic [OUT_W-1:0] outer_max;

    logic [IN_W-1:0]  inner_cnt;
    logic [OUT_W-1:0] outer_cnt;
    logic             inner_wrap;
    logic             outer_wrap;
    logic             done;
    logic             busy;

    modport master (
        output start, en, clear, mode, inner_max, outer_max,
        input  inner_cnt, outer_cnt, inner_wrap, outer_wrap, done, busy
    );

    modport slave (
        input  start, en, clear, mode, inner_max, outer_max,
        output inner_cnt, outer_cnt, inner_wrap, outer_wrap, done, busy
    );
endinterface

// File: rtl/loop_counter_2d.sv
// Two-level nested loop counter for MFCC frame/bin iteration.
// The inner count steps on each honoured en and wraps at its latched limit.
// Every inner wrap advances the outer count, which wraps at its own limit.
// In one-shot mode the outer wrap ends the sequence with a done pulse.
// In continuous mode the counter keeps cycling until clear or a new start.
// Priority each cycle: clear > start > en.
module loop_counter_2d #(
    parameter int IN_W  = 6,
    parameter int OUT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    loop_counter_2d_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;

    logic [IN_W-1:0]  inner_q, inner_d;
    logic [OUT_W-1:0] outer_q, outer_d;

    // Limits and mode are captured at start so the inputs may change mid-run.
    logic [IN_W-1:0]  inner_max_l, inner_max_d;
    logic [OUT_W-1:0] outer_max_l, outer_max_d;
    logic             mode_l, mode_d;

    logic             inner_wrap_q, inner_wrap_d;
    logic             outer_wrap_q, outer_wrap_d;
    logic             done_q, done_d;

    // Terminal detection is by equality, so an all-ones limit never overflows.
    logic             inner_last;
    logic             outer_last;
    logic             advance;

    assign inner_last = (inner_q == inner_max_l);
    assign outer_last = (outer_q == outer_max_l);
    assign advance    = (state_q == RUN) && bus.en;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-value logic for the FSM and the datapath.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d      = state_q;
        inner_d      = inner_q;
        outer_d      = outer_q;
        inner_max_d  = inner_max_l;
        outer_max_d  = outer_max_l;
        mode_d       = mode_l;
        inner_wrap_d = 1'b0;
        outer_wrap_d = 1'b0;
        done_d       = 1'b0;

        if (bus.clear) begin
            // Abort from any state; counters return to zero.
            state_d = IDLE;
            inner_d = '0;
            outer_d = '0;
        end else if (bus.start) begin
            // (Re)start: capture configuration, zero counters, en is ignored.
            state_d     = RUN;
            inner_d     = '0;
            outer_d     = '0;
            inner_max_d = bus.inner_max;
            outer_max_d = bus.outer_max;
            mode_d      = bus.mode;
        end else if (advance) begin
            if (!inner_last) begin
                inner_d = inner_q + IN_W'(1);
            end else begin
                inner_d      = '0;
                inner_wrap_d = 1'b1;
                if (!outer_last) begin
                    outer_d = outer_q + OUT_W'(1);
                end else begin
                    outer_d      = '0;
                    outer_wrap_d = 1'b1;
                    if (mode_l) begin
                        // One-shot: the last point has been visited.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    // Counter, configuration and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all control and datapath registers are reset; a stale limit
        // or mode after reset would change the first sequence silently.
        if (!rst_n) begin
            inner_q      <= '0;
            outer_q      <= '0;
            inner_max_l  <= '0;
            outer_max_l  <= '0;
            mode_l       <= 1'b0;
            inner_wrap_q <= 1'b0;
            outer_wrap_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            inner_q      <= inner_d;
            outer_q      <= outer_d;
            inner_max_l  <= inner_max_d;
            outer_max_l  <= outer_max_d;
            mode_l       <= mode_d;
            inner_wrap_q <= inner_wrap_d;
            outer_wrap_q <= outer_wrap_d;
            done_q       <= done_d;
        end
    end

    assign bus.inner_cnt  = inner_q;
    assign bus.outer_cnt  = outer_q;
    assign bus.inner_wrap = inner_wrap_q;
    assign bus.outer_wrap = outer_wrap_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q == RUN);

endmodule

// File: doc/loop_counter_2d.md
Name: loop_counter_2d

Overview:
- Two-level nested loop counter for MFCC frame/bin iteration. The inner counter steps under an enable and wraps at a programmable limit; each inner wrap advances the outer counter, which wraps at its own limit.
- Parametrised successor to the single 6-bit loop counter. Adds independent widths, limits latched at start, a run/idle FSM, one-shot and continuous modes, registered wrap and done pulses, and a synchronous clear.
- Drives address generation and stage sequencing in the MFCC datapath controllers.

Parameters:
IN_W, 6, width of inner counter and inner limit
OUT_W, 6, width of outer counter and outer limit

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: latch limits, zero counters, enter RUN
en  in  1  advance request, honoured only in RUN
clear  in  1  synchronous abort to IDLE
mode  in  1  0 = continuous (wrap forever), 1 = one-shot (stop after last point); latched at start
inner_max  in  IN_W  inner terminal value (inclusive), latched at start
outer_max  in  OUT_W  outer terminal value (inclusive), latched at start
inner_cnt  out  IN_W  current inner count
outer_cnt  out  OUT_W  current outer count
inner_wrap  out  1  registered pulse: inner wrapped on previous advance
outer_wrap  out  1  registered pulse: outer wrapped on previous advance
done  out  1  registered pulse: one-shot sequence completed
busy  out  1  high in RUN

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; inner_cnt, outer_cnt, latched limits and mode all 0; inner_wrap, outer_wrap, done, busy all 0.
- FSM states IDLE and RUN; busy = (state == RUN), decoded from the state register.
- Priority each cycle: clear > start > en.
- clear = 1, any state: next cycle state IDLE, counters 0, all pulses 0.
- start = 1 (IDLE or RUN): latch inner_max, outer_max and mode; counters 0; state RUN; pulses 0. en in the same cycle is ignored. start in RUN restarts the sequence.
- In RUN with en = 1:
  - If inner_cnt != inner_max_l: inner_cnt + 1.
  - Otherwise inner_cnt becomes 0 and inner_wrap = 1 next cycle.
    - If outer_cnt != outer_max_l: outer_cnt + 1.
    - Otherwise outer_cnt becomes 0 and outer_wrap = 1 next cycle.
      - mode_l = 1: state IDLE and done = 1 next cycle.
      - mode_l = 0: stay in RUN, no done.
- In RUN with en = 0: counters hold; pulses deassert.
- In IDLE: en ignored; counters hold their last value (0 after a one-shot completion or a clear).
- All pulses last exactly one cycle; they coincide with the updated counter values.
- Latency: one cycle from en to the counter and pulse update.
- Sequence length: (inner_max_l + 1) × (outer_max_l + 1) advances.
- Wrap is by equality against the latched limit, so arithmetic never overflows for any limit up to all-ones.
- A limit of 0 is legal:
  - inner_max_l = 0 gives inner_wrap on every advance.
  - Both limits 0 in one-shot mode gives done after one advance.
- Changing the inner_max, outer_max or mode inputs in RUN has no effect until the next start.
- Reset mid-sequence returns to the reset state immediately; no done is produced.

Test Plan:
- Reset, then start with inner_max = 2, outer_max = 1, mode = 1, en held high:
  - counter pairs (inner, outer): (1,0) (2,0) (0,1) (1,1) (2,1) (0,0);
  - inner_wrap on cycles 3 and 6; outer_wrap and done on cycle 6; busy drops on cycle 6.
- Continuous: inner_max = 1, outer_max = 0, mode = 0, en high for 6 cycles:
  - inner_cnt 1,0,1,0,1,0; outer_wrap on every inner wrap; done never; busy stays 1.
- en toggling 1,0,1,0 with inner_max = 3: counters advance only on en = 1 cycles; pulses never extend across en = 0 cycles.
- Mid-sequence events at inner = 2, outer = 1:
  - start with new limits 1/1 resets counters to 0 and uses the new limits;
  - clear asserted together with start and en leaves IDLE with counters 0.
- Boundary, IN_W = OUT_W = 6, limits 63/0, one-shot: inner reaches 63, then wraps to 0 with done after exactly 64 advances.
- Async reset pulse asserted between clock edges mid-run: outputs go to 0 without waiting for a clock; no done afterwards; en ignored until the next start.
